// File: rtl/interp_ctrl.sv
// Channel-estimate interpolation sequencer for one NB-IoT subframe (14 symbols x 12 subcarriers).
// Walks every element, launches a divide for data elements and presents each element under valid/ready.
module interp_ctrl #(
  parameter int N_SYM = 14,
  parameter int N_SC  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       div_done,
  input  logic       out_ready,
  output logic       div_start,
  output logic [1:0] sel_h2,
  output logic [3:0] sym_idx,
  output logic [3:0] sc_idx,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] LAST_SYM = 4'(N_SYM - 1);
  localparam logic [3:0] LAST_SC  = 4'(N_SC - 1);

  // Mux codes: bit 0 set means a pilot symbol (est3/est4), so no divide is needed.
  function automatic logic [1:0] sel_for(input logic [3:0] sym);
    case (sym)
      4'd5, 4'd6:   sel_for = 2'b01;
      4'd12, 4'd13: sel_for = 2'b11;
      default:      sel_for = (sym < 4'd5) ? 2'b00 : 2'b10;
    endcase
  endfunction

  logic [2:0] state_q, state_d;
  logic [3:0] sym_q, sym_d;
  logic [3:0] sc_q, sc_d;
  logic [1:0] sel_q, sel_d;

  logic       sc_wrap;
  logic       last_elem;
  logic [3:0] sym_nxt;
  logic [3:0] sc_nxt;

  assign sc_wrap   = (sc_q == LAST_SC);
  assign last_elem = sc_wrap && (sym_q == LAST_SYM);
  assign sym_nxt   = sc_wrap ? sym_q + 4'd1 : sym_q;
  assign sc_nxt    = sc_wrap ? 4'd0 : sc_q + 4'd1;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    sym_d   = sym_q;
    sc_d    = sc_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          sym_d   = 4'd0;
          sc_d    = 4'd0;
          sel_d   = sel_for(4'd0);
        end
      end
      S_ISSUE: state_d = sel_q[0] ? S_OUT : S_WAIT;
      S_WAIT: begin
        if (div_done) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (last_elem) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            sym_d   = sym_nxt;
            sc_d    = sc_nxt;
            sel_d   = sel_for(sym_nxt);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        sym_d   = 4'd0;
        sc_d    = 4'd0;
        sel_d   = 2'b00;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      sym_q   <= 4'd0;
      sc_q    <= 4'd0;
      sel_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      sc_q    <= sc_d;
      sel_q   <= sel_d;
    end
  end

  assign div_start = (state_q == S_ISSUE) && !sel_q[0];
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sel_h2    = sel_q;
  assign sym_idx   = sym_q;
  assign sc_idx    = sc_q;

endmodule

// File: tb/tb_interp_ctrl.sv
// Self-checking bench for interp_ctrl: element-stream reference model, bench-side divider
// with programmable latency, random backpressure, spurious div_done and mid-frame resets.
module tb_interp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       div_done;
  logic       out_ready;
  logic       div_start;
  logic [1:0] sel_h2;
  logic [3:0] sym_idx;
  logic [3:0] sc_idx;
  logic       out_valid;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pend  = 0;

  interp_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .div_done  (div_done),
    .out_ready (out_ready),
    .div_start (div_start),
    .sel_h2    (sel_h2),
    .sym_idx   (sym_idx),
    .sc_idx    (sc_idx),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference mapping from symbol number to mux code and symbol class.
  function automatic logic [1:0] ref_sel(input int sym);
    if (sym == 5 || sym == 6)        return 2'b01;
    else if (sym == 12 || sym == 13) return 2'b11;
    else if (sym < 5)                return 2'b00;
    else                             return 2'b10;
  endfunction

  function automatic bit ref_pilot(input int sym);
    return (sym == 5) || (sym == 6) || (sym == 12) || (sym == 13);
  endfunction

  // One clock: outputs are observed and inputs driven at the falling edge.
  // The divider model raises div_done exactly pend cycles after div_start.
  task automatic step();
    @(negedge clk);
    cyc++;
    start     = 1'b0;
    div_done  = 1'b0;
    out_ready = 1'b1;
    if (pend > 0) begin
      pend--;
      if (pend == 0) div_done = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({busy, done, out_valid, div_start, sel_h2, sym_idx, sc_idx}), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_quiet", 32'({busy, out_valid, div_start, done}), 32'd0);
    end
  endtask

  // abort_mode: 0 none, 1 two-cycle reset after abort_after cycles, 2 reset in WAIT_DIV at sym 2.
  task automatic run_frame(input int lat, input int stall_mode, input bit spur,
                           input int abort_mode, input int abort_after);
    int k, ei, stalls, divs, elem_divs, stalled;
    int n_sel[4];
    bit abort_req, aborted, finished;
    k = 0; ei = 0; stalls = 0; divs = 0; elem_divs = 0; stalled = 0;
    abort_req = 1'b0; aborted = 1'b0; finished = 1'b0;
    for (int i = 0; i < 4; i++) n_sel[i] = 0;

    check("idle_before_start", 32'(busy), 32'd0);
    start = 1'b1;
    k = cyc;
    for (int t = 0; t < 20000; t++) begin
      step();
      if (abort_req || (abort_mode == 1 && t == abort_after)) begin
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (t == 0) check("busy_after_start", 32'({busy, out_valid, done}), 32'b100);
      else if (!done) start = 1'($urandom_range(0, 1));

      if (div_start) begin
        divs++;
        elem_divs++;
        check("div_on_data_elem", 32'(ref_pilot(ei / 12)), 32'd0);
        check("div_overlap", 32'(pend), 32'd0);
        pend = lat;
        if (spur && $urandom_range(0, 1) == 1) div_done = 1'b1;
        if (abort_mode == 2 && ei == 24) abort_req = 1'b1;
      end

      if (out_valid) begin
        check("elem", 32'({sel_h2, sym_idx, sc_idx}),
              32'({ref_sel(ei / 12), 4'(ei / 12), 4'(ei % 12)}));
        if (stall_mode == 1 && ei == 6 * 12 + 3 && stalled < 5) begin
          out_ready = 1'b0;
          stalled++;
        end else if (stall_mode == 2) begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (spur && $urandom_range(0, 1) == 1) div_done = 1'b1;
        if (out_ready) begin
          check("div_per_elem", 32'(elem_divs), ref_pilot(ei / 12) ? 32'd0 : 32'd1);
          n_sel[sel_h2]++;
          ei++;
          elem_divs = 0;
        end else begin
          stalls++;
        end
      end

      if (done) begin
        check("done_cycle", 32'(cyc - k), 32'(1 + 96 + 120 * (2 + lat) + stalls));
        check("beats", 32'(ei), 32'd168);
        check("div_pulses", 32'(divs), 32'd120);
        check("sel00_count", 32'(n_sel[0]), 32'd60);
        check("sel01_count", 32'(n_sel[1]), 32'd24);
        check("sel10_count", 32'(n_sel[2]), 32'd60);
        check("sel11_count", 32'(n_sel[3]), 32'd24);
        finished = 1'b1;
        break;
      end
    end

    if (aborted) begin
      if (abort_mode == 1) step();
      step();
      rst = 1'b0;
      check_reset_outputs("reset_outputs");
    end else if (finished) begin
      step();
      check_reset_outputs("idle_after_done");
    end else begin
      check("frame_timeout", 32'd1, 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    div_done  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("por");
    rst = 1'b0;
    step();

    // Reset from a random mid-frame state, then a frame started one cycle after release.
    run_frame(3, 2, 1'b1, 1, $urandom_range(20, 300));
    step();
    check("busy_low_after_reset", 32'(busy), 32'd0);
    run_frame(3, 0, 1'b0, 0, 0);
    idle_cycles(2);

    // Five-cycle stall at (6,3).
    run_frame(3, 1, 1'b0, 0, 0);
    idle_cycles(2);

    // Single-cycle divider with spurious div_done pulses.
    run_frame(1, 0, 1'b1, 0, 0);
    idle_cycles(2);

    // Reset in WAIT_DIV at sym 2; the late div_done must not wake the sequencer.
    run_frame(3, 0, 1'b0, 2, 0);
    idle_cycles(8);
    run_frame(3, 0, 1'b0, 0, 0);
    idle_cycles(2);

    // Fully randomized frames.
    for (int r = 0; r < 3; r++) begin
      run_frame($urandom_range(1, 6), 2, 1'($urandom_range(0, 1)), 0, 0);
      idle_cycles(8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interp_ctrl.md
# interp_ctrl

Sequencer for channel-estimate interpolation over one NB-IoT subframe (14 OFDM symbols × 12 subcarriers). It walks every (symbol, subcarrier) element and drives the select of the second-port equalizer-channel mux: pilot symbols take est3/est4, data symbols take div_res_1/div_res_2. For each data element it runs a start/done handshake with the shared interpolation divider. It presents one output element at a time to the equalizer under valid/ready flow control.

## Interface
Parameters:
- N_SYM, 14, symbols per subframe (fixed at 14; pilot positions below assume it)
- N_SC, 12, subcarriers per symbol

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one subframe; sampled only in IDLE
- div_done  in  1  divider result ready; sampled only in WAIT_DIV
- out_ready  in  1  equalizer accepts the current element
- div_start  out  1  one-cycle pulse that launches a divide for the current element
- sel_h2  out  2  select code for the h_eqlz_2 mux
- sym_idx  out  4  current symbol index, 0..13
- sc_idx  out  4  current subcarrier index, 0..11
- out_valid  out  1  sel_h2, sym_idx and sc_idx are valid for the equalizer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of the subframe

## Operation
- FSM states: IDLE, ISSUE, WAIT_DIV, OUT, DONE.
- Symbol classes:
  - Pilot symbols are 5, 6, 12, 13. Every other symbol is a data symbol.
  - Pilot elements never use the divider.
- sel_h2 mapping, registered and updated on entry to ISSUE:
  - sym 5 or 6 → 01 (est3)
  - sym 12 or 13 → 11 (est4)
  - sym 0..4 → 00 (div_res_2)
  - sym 7..11 → 10 (div_res_1)
  - Code 00 in IDLE and after reset.
- IDLE:
  - start=1 → ISSUE, with sym_idx=0 and sc_idx=0.
  - start=0 → stay in IDLE.
- ISSUE:
  - Data element: div_start=1 for this cycle only, then go to WAIT_DIV.
  - Pilot element: go directly to OUT.
- WAIT_DIV:
  - Stay until div_done=1, then go to OUT.
  - No timeout.
- OUT:
  - out_valid=1.
  - If out_ready=0, hold every output stable.
  - If out_ready=1 and the element is not the last: advance sc_idx; when sc_idx wraps 11→0, increment sym_idx; go to ISSUE.
  - If out_ready=1 on the last element (sym 13, sc 11): go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. Indices return to 0.
- Ignored events:
  - start while busy=1.
  - div_done outside WAIT_DIV, including div_done in the same cycle as div_start.
- rst=1 in any state:
  - Next state is IDLE.
  - The divide in flight is abandoned; a div_done that arrives later is ignored.
- Counters:
  - sc_idx counts 0..11 and wraps to 0.
  - sym_idx counts 0..13. It never exceeds 13, and never wraps while busy.

## Timing
- Reset values: sel_h2=00, sym_idx=0, sc_idx=0, out_valid=0, div_start=0, busy=0, done=0.
- All outputs are registered, or decoded from registered state with no input-to-output combinational path.
- Divider latency L is defined as: div_done first high L cycles after the div_start cycle, with L≥1.
- Cycles per element with out_ready held high:
  - Pilot element: 2 (ISSUE, OUT).
  - Data element: 2+L (ISSUE, L cycles in WAIT_DIV, OUT).
- Full subframe: with start sampled in cycle k, done is high in cycle k+1+96+120·(2+L).
  - 48 pilot elements contribute 96 cycles; 120 data elements contribute 120·(2+L).
- Each cycle with out_ready=0 in OUT adds exactly one cycle.
- busy rises in the cycle after start is sampled and falls in the cycle after done.

## Test plan
- Reset: assert rst for 2 cycles from a random state → all outputs at reset values; one cycle later, start=1 produces busy=1 on the next cycle.
- Full subframe, L=3, out_ready=1 → done exactly 697 cycles after the start cycle.
  - 168 out_valid beats; 120 div_start pulses.
  - sel_h2 sequence: 00×60, 01×24, 10×60, 11×24.
- Backpressure: hold out_ready=0 for 5 cycles at (sym 6, sc 3) → sel_h2=01 and both indices stable for the whole stall; done arrives 5 cycles later than the no-stall case.
- Divider handshake: L=1, plus a spurious div_done during an ISSUE cycle → the spurious pulse is ignored; exactly one OUT follows each WAIT_DIV; no lost or duplicated element.
- Boundaries:
  - sc wrap 11→0 increments sym_idx.
  - sym 4→5 switches sel_h2 from 00 to 01.
  - The last element (13, 11) leads to DONE and then IDLE.
  - A start pulse during busy is ignored.
- Mid-operation reset: assert rst while in WAIT_DIV at sym 2 → IDLE next cycle with reset outputs; a late div_done has no effect; a new start runs a clean full subframe.
